debug_strobe_gen: RTL and testbench
===================================

// Module: debug_strobe_gen
// PURPOSE
//  Multi-channel debug strobe generator that drives ChipScope/ILA trigger and probe nets.
//  Each channel produces one of four waveforms on its own enable:
//   - toggle
//   - periodic pulse
//   - one-shot pulse
//   - level follow
//  All waveforms are derived from a shared programmable period.
//  The block sits beside the RLS datapath and gives a known-good heartbeat for bring-up
//  and for trigger alignment.
// PARAMETERS
//  N_CH        4   number of independent channels
//  CNT_W       16  width of the period register and of the per-channel prescaler counters
//  RST_PERIOD  0   value loaded into the period register at reset (0 = event every enabled cycle)
// PORTS
//  clk         in   1          system clock
//  reset       in   1          asynchronous, active-low reset
//  en          in   N_CH       per-channel enable, synchronous
//  mode        in   2*N_CH     per-channel mode; channel i uses mode[2i+1:2i]
//  cfg_load    in   1          single-cycle strobe: capture cfg_period
//  cfg_period  in   CNT_W      new period value; event every (cfg_period+1) enabled cycles
//  out         out  N_CH       registered strobe outputs
//  busy        out  N_CH       channel counting: en=1 and channel not in ONE_DONE
// BEHAVIOUR
//  Reset values (reset=0, asynchronous)
//   - out=0, busy=0, all counters=0, period_q=RST_PERIOD, mode_q=0, all FSMs in IDLE.
//  Prescaler, per channel
//   - When en[i]=1 and the channel is not frozen, cnt increments each cycle.
//   - Terminal event `tc` when cnt==period_q; cnt then wraps to 0 on the same edge.
//   - en[i]=0: cnt holds its value; it is not cleared.
//  Modes (mode_q, registered copy of mode)
//   - 00 TOGGLE: out flips on each tc. With period_q=0 this is the legacy toggle-per-enabled-cycle.
//   - 01 PULSE: out=1 for exactly the cycle after tc, otherwise 0.
//   - 10 ONESHOT: FSM IDLE -> COUNT -> FIRE -> DONE.
//       - IDLE -> COUNT on en=1.
//       - COUNT -> FIRE on tc; out=1 for one cycle.
//       - FIRE -> DONE unconditionally; out=0, cnt frozen at 0, busy=0.
//       - DONE -> IDLE only when en=0; re-arm needs en to fall and rise again.
//       - en=0 in COUNT: stays in COUNT with cnt held.
//   - 11 LEVEL: out = en registered (1-cycle latency); cnt is held at 0.
//  Latency
//   - out reflects tc on the next clock edge (1 cycle).
//   - First event after enable: period_q+1 enabled cycles after en rises, with cnt=0 at start.
//  Configuration
//   - cfg_load=1: period_q <= cfg_period.
//   - On the same edge, every channel has cnt cleared to 0 and its ONESHOT FSM returned to IDLE.
//   - out is unchanged for TOGGLE/LEVEL and forced to 0 for PULSE/ONESHOT.
//  Mode change
//   - mode[i] != mode_q[i] on an edge: channel i restarts.
//   - Restart: mode_q updated, cnt=0, out=0, FSM=IDLE. No tc is acted on that cycle.
//  Simultaneous events
//   - cfg_load beats tc: no event that cycle.
//   - Mode change beats tc.
//   - cfg_load together with a mode change: both apply; the channel restarts.
//  Width and arithmetic
//   - cnt is unsigned CNT_W bits; compare is equality only.
//   - cnt never exceeds period_q, because any period update clears cnt.
//  Reset mid-operation
//   - Immediate return to the reset values above, including a mid-pulse out.
//  busy
//   - busy[i] = en[i] & (mode_q[i] != LEVEL) & (FSM not DONE/IDLE for ONESHOT).
//   - busy is registered alongside out.
// STRUCTURE
//  Package debug_strobe_pkg holds:
//   - localparams MODE_TOGGLE=2'b00, MODE_PULSE=2'b01, MODE_ONESHOT=2'b10, MODE_LEVEL=2'b11.
//   - ONESHOT state encodings OS_IDLE, OS_COUNT, OS_FIRE, OS_DONE (2 bits).
//  Sub-module debug_strobe_ch
//   - One channel: cnt, mode_q, ONESHOT FSM, out, busy.
//   - Inputs: period_q, a clear strobe, en, mode.
//  Top level
//   - Owns period_q and the cfg_load clear.
//   - Instantiates N_CH copies of debug_strobe_ch in a generate loop.
// TESTING
//  1 TOGGLE, period 0: reset release, mode=00, en[0]=1 for 6 cycles -> out[0] = 1,0,1,0,1,0; en=0 holds the last value.
//  2 PULSE, period 3: cfg_load, cfg_period=3, mode=01, en[1]=1 -> out[1] high one cycle every 4, first at cycle 4 after en.
//  3 ONESHOT, period 2:
//    - en[2] held 10 cycles -> single out[2] pulse at cycle 3; busy[2] drops after it.
//    - en low 1 cycle then high -> second pulse 3 cycles later.
//  4 Mid-count reload: period 5, cnt=3; cfg_load with cfg_period=1 -> cnt=0, next tc 2 cycles later; no spurious pulse.
//  5 Collision: tc and mode change 00->01 on the same edge -> out=0, no toggle; tc and cfg_load together -> no event.
//  6 Async reset: assert reset while a PULSE is high and a TOGGLE sits at out=1 -> all out=0 before the next clk edge; period_q=RST_PERIOD.

Source files
------------

// File: rtl/debug_strobe_pkg.sv
// debug_strobe_pkg
//   Shared definitions for the debug strobe generator.
//   - Channel mode encodings, matching the 2-bit fields of the mode bus.
//   - ONESHOT state encodings.
package debug_strobe_pkg;

    localparam logic [1:0] MODE_TOGGLE  = 2'b00;
    localparam logic [1:0] MODE_PULSE   = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_LEVEL   = 2'b11;

    typedef enum logic [1:0] {
        OS_IDLE  = 2'b00,
        OS_COUNT = 2'b01,
        OS_FIRE  = 2'b10,
        OS_DONE  = 2'b11
    } os_state_e;

    // A channel reports busy only while it is enabled and actually counting
    // toward an event. LEVEL never counts, and ONESHOT is idle before arming
    // and after its single pulse.
    function automatic logic ch_busy(input logic en, input logic [1:0] mode,
                                     input os_state_e os);
        logic oneshot_idle;
        oneshot_idle = (mode == MODE_ONESHOT) && (os == OS_IDLE || os == OS_DONE);
        return en && (mode != MODE_LEVEL) && !oneshot_idle;
    endfunction

endpackage

// File: rtl/debug_strobe_ch.sv
// debug_strobe_ch
//   One strobe channel: prescaler counter, registered mode, ONESHOT FSM,
//   registered out and busy.
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   period_q  in   shared period; an event (tc) occurs when cnt == period_q
//   clr       in   configuration reload strobe: clear cnt, FSM back to IDLE
//   en        in   channel enable
//   mode      in   requested mode (see debug_strobe_pkg)
//   out       out  registered strobe
//   busy      out  registered "channel counting" flag
module debug_strobe_ch
    import debug_strobe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period_q,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             out,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    os_state_e        os_q, os_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;

    logic             tc;
    logic [CNT_W-1:0] cnt_adv;

    // Equality compare only: any period update clears cnt, so cnt can
    // never be above period_q.
    assign tc      = (cnt_q == period_q);
    assign cnt_adv = tc ? '0 : cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            mode_q <= MODE_TOGGLE;
            os_q   <= OS_IDLE;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            os_q   <= os_d;
            out_q  <= out_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        os_d   = os_q;
        out_d  = out_q;

        if (mode != mode_q) begin
            // Restart wins over both tc and a reload; any reload is
            // covered since the restart also clears cnt and the FSM.
            mode_d = mode;
            cnt_d  = '0;
            out_d  = 1'b0;
            os_d   = OS_IDLE;
        end else if (clr) begin
            // Reload beats tc. Pulse-type outputs are dropped so no
            // stale pulse survives a period change; TOGGLE/LEVEL keep state.
            cnt_d = '0;
            os_d  = OS_IDLE;
            if (mode_q == MODE_PULSE || mode_q == MODE_ONESHOT) begin
                out_d = 1'b0;
            end
        end else begin
            case (mode_q)
                MODE_TOGGLE: begin
                    if (en) begin
                        cnt_d = cnt_adv;
                        if (tc) begin
                            out_d = ~out_q;
                        end
                    end
                end
                MODE_PULSE: begin
                    out_d = en && tc;
                    if (en) begin
                        cnt_d = cnt_adv;
                    end
                end
                MODE_ONESHOT: begin
                    out_d = 1'b0;
                    case (os_q)
                        // The arming cycle counts too, so the pulse lands
                        // period_q+1 enabled cycles after en rises.
                        OS_IDLE, OS_COUNT: begin
                            if (en) begin
                                cnt_d = cnt_adv;
                                if (tc) begin
                                    os_d  = OS_FIRE;
                                    out_d = 1'b1;
                                end else begin
                                    os_d = OS_COUNT;
                                end
                            end
                        end
                        OS_FIRE: begin
                            os_d  = OS_DONE;
                            cnt_d = '0;
                        end
                        OS_DONE: begin
                            // Re-arm only after en has been seen low.
                            cnt_d = '0;
                            if (!en) begin
                                os_d = OS_IDLE;
                            end
                        end
                        default: os_d = OS_IDLE;
                    endcase
                end
                default: begin
                    // LEVEL: registered follow of en, counter parked.
                    cnt_d = '0;
                    out_d = en;
                end
            endcase
        end

        // Computed from next-state values so busy lines up with out.
        busy_d = ch_busy(en, mode_d, os_d);
    end

    assign out  = out_q;
    assign busy = busy_q;

endmodule

// File: rtl/debug_strobe_gen.sv
// debug_strobe_gen
//   Multi-channel debug strobe generator for ILA trigger/probe nets. Each
//   channel makes a TOGGLE, PULSE, ONESHOT or LEVEL waveform from a shared
//   programmable period.
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   en          in   per-channel enable
//   mode        in   per-channel mode, channel i uses mode[2i+1:2i]
//   cfg_load    in   strobe: capture cfg_period, clear all channel counters
//   cfg_period  in   new period; event every cfg_period+1 enabled cycles
//   out         out  registered strobe outputs
//   busy        out  registered per-channel counting flags
module debug_strobe_gen
    import debug_strobe_pkg::*;
#(
    parameter int                N_CH       = 4,
    parameter int                CNT_W      = 16,
    parameter logic [CNT_W-1:0]  RST_PERIOD = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     en,
    input  logic [2*N_CH-1:0]   mode,
    input  logic                cfg_load,
    input  logic [CNT_W-1:0]    cfg_period,
    output logic [N_CH-1:0]     out,
    output logic [N_CH-1:0]     busy
);

    logic [CNT_W-1:0] period_q, period_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_q <= RST_PERIOD;
        end else begin
            period_q <= period_d;
        end
    end

    always_comb begin
        period_d = period_q;
        if (cfg_load) begin
            period_d = cfg_period;
        end
    end

    // Channels compare against the current period; on a reload edge the
    // clear strobe overrides any tc, so the new period takes effect from
    // cnt = 0 on the following cycle.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debug_strobe_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .period_q (period_q),
            .clr      (cfg_load),
            .en       (en[i]),
            .mode     (mode[2*i+1:2*i]),
            .out      (out[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_debug_strobe_gen.sv
module tb_debug_strobe_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  en;
    logic [7:0]  mode;
    logic        cfg_load;
    logic [15:0] cfg_period;
    logic [3:0]  out;
    logic [3:0]  busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic [3:0] out;
        logic [3:0] busy;
    } exp_t;

    exp_t sb[$];
    bit   stim_done = 1'b0;

    debug_strobe_gen #(
        .N_CH       (4),
        .CNT_W      (16),
        .RST_PERIOD (16'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .cfg_load   (cfg_load),
        .cfg_period (cfg_period),
        .out        (out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Queue the expected outputs after the coming edge, then take that edge.
    task automatic step(input string name, input logic [3:0] eo, input logic [3:0] eb);
        exp_t e;
        e.name = name;
        e.out  = eo;
        e.busy = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are registered, so each edge presents one response.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".out"},  out,  e.out);
            chk({e.name, ".busy"}, busy, e.busy);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: stimulus not finished, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        en         = 4'b0000;
        mode       = 8'h00;
        cfg_load   = 1'b0;
        cfg_period = 16'd0;
        #1;
        chk("reset.out",  out,  4'b0000);
        chk("reset.busy", busy, 4'b0000);
        step("rst", 4'b0000, 4'b0000);
        step("rst", 4'b0000, 4'b0000);
        reset = 1'b1;

        // 1: TOGGLE, period 0 -> flips every enabled cycle, then holds.
        en = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            step("t1_toggle", (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
        end
        en = 4'b0000;
        step("t1_hold", 4'b0001, 4'b0000);
        step("t1_hold", 4'b0001, 4'b0000);

        // 2: PULSE on ch1, period 3.
        cfg_load = 1'b1; cfg_period = 16'd3; mode = 8'b0000_0100;
        step("t2_cfg", 4'b0001, 4'b0000);
        cfg_load = 1'b0; en = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            step("t2_pulse", (i % 4 == 0) ? 4'b0011 : 4'b0001, 4'b0010);
        end
        en = 4'b0000;
        step("t2_off", 4'b0001, 4'b0000);

        // 3: ONESHOT on ch2, period 2.
        cfg_load = 1'b1; cfg_period = 16'd2; mode = 8'b0010_0100;
        step("t3_cfg", 4'b0001, 4'b0000);
        cfg_load = 1'b0; en = 4'b0100;
        step("t3_os", 4'b0001, 4'b0100);
        step("t3_os", 4'b0001, 4'b0100);
        step("t3_fire", 4'b0101, 4'b0100);
        for (int i = 0; i < 7; i++) begin
            step("t3_done", 4'b0001, 4'b0000);
        end
        en = 4'b0000;
        step("t3_rearm", 4'b0001, 4'b0000);
        en = 4'b0100;
        step("t3_os2", 4'b0001, 4'b0100);
        step("t3_os2", 4'b0001, 4'b0100);
        step("t3_fire2", 4'b0101, 4'b0100);
        step("t3_done2", 4'b0001, 4'b0000);
        en = 4'b0000;
        step("t3_idle", 4'b0001, 4'b0000);
        // en low while counting holds the count.
        en = 4'b0100;
        step("t3_arm", 4'b0001, 4'b0100);
        en = 4'b0000;
        step("t3_pause", 4'b0001, 4'b0000);
        step("t3_pause", 4'b0001, 4'b0000);
        en = 4'b0100;
        step("t3_resume", 4'b0001, 4'b0100);
        step("t3_fire3", 4'b0101, 4'b0100);
        step("t3_done3", 4'b0001, 4'b0000);
        en = 4'b0000;
        step("t3_idle2", 4'b0001, 4'b0000);

        // 4: mid-count reload on ch1 PULSE: period 5, reload to 1 at cnt=3.
        cfg_load = 1'b1; cfg_period = 16'd5;
        step("t4_cfg", 4'b0001, 4'b0000);
        cfg_load = 1'b0; en = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step("t4_count", 4'b0001, 4'b0010);
        end
        cfg_load = 1'b1; cfg_period = 16'd1;
        step("t4_reload", 4'b0001, 4'b0010);
        cfg_load = 1'b0;
        step("t4_post", 4'b0001, 4'b0010);
        step("t4_tc", 4'b0011, 4'b0010);
        step("t4_post", 4'b0001, 4'b0010);
        step("t4_tc", 4'b0011, 4'b0010);
        en = 4'b0000;
        step("t4_off", 4'b0001, 4'b0000);

        // 5: collisions on ch0 (TOGGLE at out=1, period 1).
        en = 4'b0001;
        step("t5_pre", 4'b0001, 4'b0001);
        mode = 8'b0010_0101;
        step("t5_modechg", 4'b0000, 4'b0001);
        step("t5_pulse", 4'b0000, 4'b0001);
        step("t5_pulse", 4'b0001, 4'b0001);
        step("t5_pulse", 4'b0000, 4'b0001);
        cfg_load = 1'b1; cfg_period = 16'd1;
        step("t5_cfgtc", 4'b0000, 4'b0001);
        cfg_load = 1'b0;
        step("t5_after", 4'b0000, 4'b0001);
        step("t5_after", 4'b0001, 4'b0001);

        // 6: async reset with ch0 PULSE high and ch3 TOGGLE at 1.
        en = 4'b1001;
        step("t6_pre", 4'b0000, 4'b1001);
        step("t6_pre", 4'b1001, 4'b1001);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async.out",  out,  4'b0000);
        chk("t6_async.busy", busy, 4'b0000);
        mode = 8'h00; en = 4'b0001;
        step("t6_inrst", 4'b0000, 4'b0000);
        reset = 1'b1;
        // Period back to 0: toggle every enabled cycle.
        step("t6_period", 4'b0001, 4'b0001);
        step("t6_period", 4'b0000, 4'b0001);
        step("t6_period", 4'b0001, 4'b0001);
        en = 4'b0000;
        stim_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!(stim_done && sb.size() == 0) && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2000) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
